// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core definitions for the five-stage RISC-V pipeline.
//               Holds the EX operand-forwarding select encoding and the
//               hazard-controller FSM state type.
// Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // EX operand-mux select encoding.
    localparam logic [1:0] FWD_RF   = 2'b00;  // register-file value
    localparam logic [1:0] FWD_RSVD = 2'b01;  // reserved, never driven
    localparam logic [1:0] FWD_EXM  = 2'b10;  // EX/MEM result
    localparam logic [1:0] FWD_MWB  = 2'b11;  // MEM/WB result

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fwd_select_calc.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select_calc
// Description : Combinational forwarding-select priority compare for one
//               source operand of the instruction in ID.
// Ports       : rs, rs_used        - source index and its use flag
//               ex_rd, ex_we       - ID/EX destination shadow
//               mem_rd, mem_we     - EX/MEM destination shadow
//               sel                - next forwarding select
// Revision    : 1.0  initial release
// ============================================================================
module fwd_select_calc
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    output logic [1:0]        sel
);

    // The younger producer (now in ID/EX, in EX/MEM next cycle) wins over
    // the older one. x0 is hard-wired zero and is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (rs_used && ex_we && (ex_rd != '0) && (ex_rd == rs)) begin
            sel = FWD_EXM;
        end else if (rs_used && mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MWB;
        end
    end

endmodule : fwd_select_calc
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Pipeline hazard controller. Shadows the destination state of
//               ID/EX, EX/MEM and MEM/WB, detects load-use hazards (stall +
//               ID/EX bubble) and registers the EX forwarding selects.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               id_rs1/2, id_rs1/2_used       - ID source operands
//               id_rd, id_reg_write,
//               id_mem_read                   - ID destination info
//               flush                         - squash ID instruction
//               hold                          - global freeze
//               stall                         - combinational load-use stall
//               operand1/2_select             - registered EX forward selects
//               stall_count                   - saturating stall-cycle count
// Revision    : 1.0  initial release
// ============================================================================
module hazard_forward_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic [1:0]        operand1_select,
    output logic [1:0]        operand2_select,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic              r_ex_we, r_mem_we, r_wb_we;
    logic              r_ex_load, r_mem_load;
    logic [1:0]        r_sel1, r_sel2;
    logic [CNT_W-1:0]  r_stall_count;
    hz_state_t         r_state;

    logic [1:0]        w_sel1, w_sel2;
    logic              w_stall;
    logic              w_unused;

    // MEM/WB shadow and the EX/MEM load flag are kept for pipeline
    // visibility; WB-to-ID hazards are covered by register-file write-through.
    assign w_unused = ^{r_mem_load, r_wb_rd, r_wb_we};

    assign w_stall = r_ex_load && r_ex_we && (r_ex_rd != '0) &&
                     ((id_rs1_used && (r_ex_rd == id_rs1)) ||
                      (id_rs2_used && (r_ex_rd == id_rs2))) && !flush;

    fwd_select_calc #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .rs      (id_rs1),
        .rs_used (id_rs1_used),
        .ex_rd   (r_ex_rd),
        .ex_we   (r_ex_we),
        .mem_rd  (r_mem_rd),
        .mem_we  (r_mem_we),
        .sel     (w_sel1)
    );

    fwd_select_calc #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .rs      (id_rs2),
        .rs_used (id_rs2_used),
        .ex_rd   (r_ex_rd),
        .ex_we   (r_ex_we),
        .mem_rd  (r_mem_rd),
        .mem_we  (r_mem_we),
        .sel     (w_sel2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rd       <= '0;
            r_ex_we       <= 1'b0;
            r_ex_load     <= 1'b0;
            r_mem_rd      <= '0;
            r_mem_we      <= 1'b0;
            r_mem_load    <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_we       <= 1'b0;
            r_sel1        <= FWD_RF;
            r_sel2        <= FWD_RF;
            r_stall_count <= '0;
            r_state       <= RUN;
        end else if (!hold) begin
            r_wb_rd    <= r_mem_rd;
            r_wb_we    <= r_mem_we;
            r_mem_rd   <= r_ex_rd;
            r_mem_we   <= r_ex_we;
            r_mem_load <= r_ex_load;

            if (flush || w_stall) begin
                // Bubble: the ID instruction does not enter EX this cycle.
                r_ex_rd   <= '0;
                r_ex_we   <= 1'b0;
                r_ex_load <= 1'b0;
                r_sel1    <= FWD_RF;
                r_sel2    <= FWD_RF;
            end else begin
                r_ex_rd   <= id_rd;
                r_ex_we   <= id_reg_write;
                r_ex_load <= id_mem_read;
                r_sel1    <= w_sel1;
                r_sel2    <= w_sel2;
            end

            case (r_state)
                RUN: begin
                    if (w_stall) begin
                        r_state <= STALL;
                        if (r_stall_count != '1) begin
                            r_stall_count <= r_stall_count + c_cnt_one;
                        end
                    end
                end
                // The bubble now sits in ID/EX, so the hazard is clear.
                STALL:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    assign stall           = w_stall;
    assign operand1_select = r_sel1;
    assign operand2_select = r_sel2;
    assign stall_count     = r_stall_count;

endmodule : hazard_forward_ctrl
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Self-checking bench for hazard_forward_ctrl. Directed
//               instruction sequences followed by randomized traffic, both
//               checked against a pipeline-occupancy reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic              id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic              id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic              flush = 1'b0, hold = 1'b0;
    logic              stall;
    logic [1:0]        operand1_select, operand2_select;
    logic [CNT_W-1:0]  stall_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the three downstream pipeline slots, index 0 = EX,
    // 1 = MEM, 2 = WB, each holding the destination of the instruction there.
    int m_rd[3];
    bit m_we[3];
    bit m_ld[3];
    int m_sel1, m_sel2, m_cnt;

    hazard_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .flush           (flush),
        .hold            (hold),
        .stall           (stall),
        .operand1_select (operand1_select),
        .operand2_select (operand2_select),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 3; s++) begin
            m_rd[s] = 0; m_we[s] = 0; m_ld[s] = 0;
        end
        m_sel1 = 0; m_sel2 = 0; m_cnt = 0;
    endfunction

    // Nearest in-flight producer of a register, searching EX then MEM.
    function automatic int model_fwd(int rs, bit used);
        if (!used || rs == 0) return 0;
        for (int s = 0; s < 2; s++)
            if (m_we[s] && m_rd[s] == rs) return (s == 0) ? 2 : 3;
        return 0;
    endfunction

    function automatic bit model_hazard();
        bit dep;
        dep = (id_rs1_used && int'(id_rs1) == m_rd[0]) ||
              (id_rs2_used && int'(id_rs2) == m_rd[0]);
        return m_ld[0] && m_we[0] && (m_rd[0] != 0) && dep && !flush;
    endfunction

    function automatic void model_clock(bit hz);
        int n1, n2;
        if (hold) return;
        n1 = model_fwd(int'(id_rs1), id_rs1_used);
        n2 = model_fwd(int'(id_rs2), id_rs2_used);
        for (int s = 2; s > 0; s--) begin
            m_rd[s] = m_rd[s-1]; m_we[s] = m_we[s-1]; m_ld[s] = m_ld[s-1];
        end
        if (flush || hz) begin
            m_rd[0] = 0; m_we[0] = 0; m_ld[0] = 0;
            m_sel1 = 0; m_sel2 = 0;
            if (hz && m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_rd[0] = int'(id_rd); m_we[0] = id_reg_write; m_ld[0] = id_mem_read;
            m_sel1 = n1; m_sel2 = n2;
        end
    endfunction

    task automatic check_regs(input string where);
        check({where, ".sel1"}, int'(operand1_select), m_sel1);
        check({where, ".sel2"}, int'(operand2_select), m_sel2);
        check({where, ".cnt"},  int'(stall_count), m_cnt);
    endtask

    // One ID-stage cycle: drive at negedge, check stall mid-cycle, advance
    // the model at the edge and check the registered outputs just after.
    task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input bit ld,
                         input bit fl, input bit hd);
        bit hz;
        @(negedge clk);
        id_rs1 = REG_AW'(rs1); id_rs1_used = u1;
        id_rs2 = REG_AW'(rs2); id_rs2_used = u2;
        id_rd = REG_AW'(rd); id_reg_write = we; id_mem_read = ld;
        flush = fl; hold = hd;
        #1;
        hz = model_hazard();
        check("stall", int'(stall), int'(hz));
        @(posedge clk);
        model_clock(hz);
        #1;
        check_regs("pipe");
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.stall", int'(stall), 0);
        check_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check("por.sel1", int'(operand1_select), 0);
        check("por.cnt", int'(stall_count), 0);
        do_reset();

        // addi x5 ; add x6,x5,x7
        issue(0, 1, 0, 0, 5, 1, 0, 0, 0);
        issue(5, 1, 7, 1, 6, 1, 0, 0, 0);
        check("exm.sel1", int'(operand1_select), 2);
        check("exm.sel2", int'(operand2_select), 0);

        // addi x5 ; nop ; sub x8,x1,x5
        repeat (3) nop();
        issue(0, 1, 0, 0, 5, 1, 0, 0, 0);
        nop();
        issue(1, 1, 5, 1, 8, 1, 0, 0, 0);
        check("mwb.sel2", int'(operand2_select), 3);

        // lw x5 ; add x6,x5,x5 (stalls once, then reissued from ID)
        repeat (3) nop();
        issue(0, 1, 0, 0, 5, 1, 1, 0, 0);
        issue(5, 1, 5, 1, 6, 1, 0, 0, 0);
        check("lu.bubble_sel1", int'(operand1_select), 0);
        check("lu.cnt", int'(stall_count), 1);
        issue(5, 1, 5, 1, 6, 1, 0, 0, 0);
        check("lu.sel1", int'(operand1_select), 3);
        check("lu.sel2", int'(operand2_select), 3);

        // writers to x0, including lw x0
        repeat (3) nop();
        issue(0, 1, 0, 0, 0, 1, 0, 0, 0);
        issue(0, 1, 0, 1, 9, 1, 0, 0, 0);
        check("x0.sel1", int'(operand1_select), 0);
        issue(0, 1, 0, 0, 0, 1, 1, 0, 0);
        issue(0, 1, 0, 1, 9, 1, 0, 0, 0);
        check("x0.sel2", int'(operand2_select), 0);

        // lw x5 ; dependent with flush
        repeat (3) nop();
        issue(0, 1, 0, 0, 5, 1, 1, 0, 0);
        issue(5, 1, 0, 0, 6, 1, 0, 1, 0);
        check("fl.sel1", int'(operand1_select), 0);
        check("fl.cnt", int'(stall_count), 1);

        // hold during a load-use stall, then reset while in STALL
        repeat (3) nop();
        issue(0, 1, 0, 0, 5, 1, 1, 0, 0);
        repeat (3) issue(5, 1, 0, 0, 6, 1, 0, 0, 1);
        check("hold.cnt", int'(stall_count), 1);
        issue(5, 1, 0, 0, 6, 1, 0, 0, 0);
        do_reset();
        nop();

        // saturation of the narrow stall counter
        for (int k = 0; k < 4; k++) begin
            issue(0, 1, 0, 0, 3, 1, 1, 0, 0);
            issue(3, 1, 0, 0, 4, 1, 0, 0, 0);
            issue(3, 1, 0, 0, 4, 1, 0, 0, 0);
        end
        check("sat.cnt", int'(stall_count), CNT_MAX);
        do_reset();

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            issue(int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_forward_ctrl
`default_nettype wire
